// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: n/a (wires only); the stage drives a registered request, memory answers with a one-cycle ack.
// Backpressure: the request is held until memory pulses dm_ack (or the stage abandons it).
// Ports: master = MEM stage (drives request fields), slave = data memory (drives rdata/ack).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_be;
  logic [63:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: runs load/store transactions on the data-memory bus and registers MEM/WB results.
// Latency: non-memory ops 1 cycle; memory ops 2 cycles minimum plus one per cycle without dm_ack.
// Backpressure: mem_stall holds upstream while a request is outstanding; the request is abandoned after MAX_WAIT cycles.
// Ports: clk/reset (async, active-low); ex_* EX/MEM register inputs; dm (mem_stage_if.master) memory bus;
//        mem_stall to upstream; wb_* registered MEM/WB outputs; mem_err sticky timeout flag.
// Option: define MEM_BYTE_ACCESS_EN to honour ex_byte (single-byte lanes); otherwise every access is a doubleword.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_byte,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  mem_stage_if.master dm,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  // Counter value in the last REQ cycle allowed before the access is abandoned.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q;
  logic        req_q, we_q;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  be_q;
  logic        mem_op, ack, timeout, stall_raw, rd_ok;
  logic [63:0] addr_d, wdata_d, load_data;
  logic [7:0]  be_d;

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_be    = be_q;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  assign rd_ok  = (ex_rd != 5'd31);   // XZR never gets written

  // Request fields and load-data extraction depend on the access-size option.
`ifdef MEM_BYTE_ACCESS_EN
  logic byte_q;

  always_comb begin
    addr_d  = {ex_alu_result[63:3], 3'b000};
    be_d    = 8'hFF;
    wdata_d = ex_store_data;
    if (ex_byte) begin
      addr_d  = ex_alu_result;
      be_d    = 8'h01 << ex_alu_result[2:0];
      wdata_d = {8{ex_store_data[7:0]}};
    end
  end

  always_comb begin
    load_data = dm.dm_rdata;
    if (byte_q) load_data = {56'h0, dm.dm_rdata[{addr_q[2:0], 3'b000} +: 8]};
  end
`else
  logic byte_unused;
  assign byte_unused = ex_byte;

  always_comb begin
    addr_d    = {ex_alu_result[63:3], 3'b000};
    be_d      = 8'hFF;
    wdata_d   = ex_store_data;
    load_data = dm.dm_rdata;
  end
`endif

  // Next state and stall. An ack in the final REQ cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    ack       = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d   = REQ;
          stall_raw = 1'b1;
        end
      end
      REQ: begin
        ack       = dm.dm_ack;
        timeout   = ~dm.dm_ack & (wait_cnt_q == LAST_CNT);
        stall_raw = ~(ack | timeout);
        if (ack | timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Upstream must never be frozen while the core is held in reset.
  assign mem_stall = stall_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 64'h0;
      wdata_q      <= 64'h0;
      be_q         <= 8'h0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 64'h0;
      mem_err      <= 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
      byte_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Memory ops leave a bubble here; the real result lands when the ack arrives.
          wb_valid     <= ex_valid & ~mem_op;
          wb_reg_write <= ex_valid & ~mem_op & ex_reg_write & rd_ok;
          wb_rd        <= ex_rd;
          wb_data      <= ex_alu_result;
          if (mem_op) begin
            req_q      <= 1'b1;
            we_q       <= ex_mem_write;   // read+write together is a store
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wait_cnt_q <= 8'd0;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q     <= ex_byte;
`endif
          end
        end
        REQ: begin
          if (ack) begin
            // EX/MEM was held during the wait, so ex_* still describe this op.
            wb_valid     <= 1'b1;
            wb_reg_write <= ex_valid & ex_reg_write & rd_ok;
            wb_rd        <= ex_rd;
            wb_data      <= ex_mem_to_reg ? load_data : ex_alu_result;
            req_q        <= 1'b0;
            wait_cnt_q   <= 8'd0;
          end else if (timeout) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            req_q        <= 1'b0;
            mem_err      <= 1'b1;
            wait_cnt_q   <= 8'd0;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wait_cnt_q   <= wait_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MAX_WAIT = 4.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after settling.
// Backpressure: the bench plays data memory and chooses in which REQ cycle to ack.
module tb_mem_stage;
  logic        clk;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_byte, ex_mem_to_reg, ex_reg_write;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_stall, wb_valid, wb_reg_write, mem_err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_if dm_bus ();

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_byte       (ex_byte),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .dm            (dm_bus.master),
    .mem_stall     (mem_stall),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic by,
                       input logic m2r, input logic rw, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] sd);
    ex_valid      = v;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_byte       = by;
    ex_mem_to_reg = m2r;
    ex_reg_write  = rw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
  endtask

  initial begin
    reset = 1'b0;
    dm_bus.dm_ack   = 1'b0;
    dm_bus.dm_rdata = 64'h0;
    // A load is presented during reset: no stall may escape.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 64'h40, 64'h0);
    chk("rst_stall", {63'h0, mem_stall}, 64'd0);
    chk("rst_req", {63'h0, dm_bus.dm_req}, 64'd0);
    chk("rst_wb_valid", {63'h0, wb_valid}, 64'd0);
    chk("rst_mem_err", {63'h0, mem_err}, 64'd0);
    step();
    step();
    chk("rst_addr", dm_bus.dm_addr, 64'h0);
    chk("rst_be", {56'h0, dm_bus.dm_be}, 64'h0);
    bubble();
    reset = 1'b1;

    // ADD: one-cycle pass-through, never stalls.
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 64'h1234, 64'h0);
    chk("add_stall", {63'h0, mem_stall}, 64'd0);
    step();
    chk("add_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("add_wb_data", wb_data, 64'h1234);
    chk("add_wb_rd", {59'h0, wb_rd}, 64'd3);
    chk("add_wb_rw", {63'h0, wb_reg_write}, 64'd1);

    // Write to XZR: valid result, write enable suppressed. Stray ack in IDLE ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 64'h55, 64'h0);
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 64'hFFFF;
    #1;
    chk("xzr_stall", {63'h0, mem_stall}, 64'd0);
    step();
    dm_bus.dm_ack = 1'b0;
    chk("xzr_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("xzr_wb_rw", {63'h0, wb_reg_write}, 64'd0);
    chk("xzr_wb_data", wb_data, 64'h55);
    chk("xzr_no_req", {63'h0, dm_bus.dm_req}, 64'd0);

    // LDUR at 0x40, ack in the 3rd REQ cycle: stall for 3 cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 64'h40, 64'h0);
    chk("ld_stall_idle", {63'h0, mem_stall}, 64'd1);
    step();
    chk("ld_req1", {63'h0, dm_bus.dm_req}, 64'd1);
    chk("ld_addr", dm_bus.dm_addr, 64'h40);
    chk("ld_we", {63'h0, dm_bus.dm_we}, 64'd0);
    chk("ld_bubble", {63'h0, wb_valid}, 64'd0);
    chk("ld_stall_req1", {63'h0, mem_stall}, 64'd1);
    step();
    chk("ld_stall_req2", {63'h0, mem_stall}, 64'd1);
    step();
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 64'hDEADBEEF;
    #1;
    chk("ld_stall_ack", {63'h0, mem_stall}, 64'd0);
    step();
    dm_bus.dm_ack = 1'b0;
    chk("ld_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("ld_wb_data", wb_data, 64'hDEADBEEF);
    chk("ld_wb_rd", {59'h0, wb_rd}, 64'd5);
    chk("ld_req_drop", {63'h0, dm_bus.dm_req}, 64'd0);

    // STUR Db=0xA5 at 0x10, ack in the 1st REQ cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 64'h10, 64'hA5);
    chk("st_stall_idle", {63'h0, mem_stall}, 64'd1);
    step();
    chk("st_we", {63'h0, dm_bus.dm_we}, 64'd1);
    chk("st_be", {56'h0, dm_bus.dm_be}, 64'hFF);
    chk("st_wdata", dm_bus.dm_wdata, 64'hA5);
    chk("st_addr", dm_bus.dm_addr, 64'h10);
    dm_bus.dm_ack = 1'b1;
    #1;
    chk("st_stall_ack", {63'h0, mem_stall}, 64'd0);
    step();
    dm_bus.dm_ack = 1'b0;
    chk("st_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("st_wb_rw", {63'h0, wb_reg_write}, 64'd0);

    // Back-to-back LDUR with no ack: IDLE first, then timeout after 4 REQ cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 64'h80, 64'h0);
    chk("to_idle_no_req", {63'h0, dm_bus.dm_req}, 64'd0);
    chk("to_stall_idle", {63'h0, mem_stall}, 64'd1);
    step();
    chk("to_stall_r1", {63'h0, mem_stall}, 64'd1);
    step();
    chk("to_stall_r2", {63'h0, mem_stall}, 64'd1);
    step();
    chk("to_stall_r3", {63'h0, mem_stall}, 64'd1);
    chk("to_err_early", {63'h0, mem_err}, 64'd0);
    step();
    chk("to_req_r4", {63'h0, dm_bus.dm_req}, 64'd1);
    chk("to_stall_r4", {63'h0, mem_stall}, 64'd0);
    step();
    chk("to_req_drop", {63'h0, dm_bus.dm_req}, 64'd0);
    chk("to_mem_err", {63'h0, mem_err}, 64'd1);
    chk("to_wb_valid", {63'h0, wb_valid}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 64'h99, 64'h0);
    chk("resume_stall", {63'h0, mem_stall}, 64'd0);
    step();
    chk("resume_wb_data", wb_data, 64'h99);
    chk("resume_err_sticky", {63'h0, mem_err}, 64'd1);

    // Ack in the last allowed REQ cycle beats the timeout.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 64'h48, 64'h0);
    step();
    step();
    step();
    step();
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 64'h77;
    #1;
    chk("late_ack_stall", {63'h0, mem_stall}, 64'd0);
    step();
    dm_bus.dm_ack = 1'b0;
    chk("late_ack_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("late_ack_wb_data", wb_data, 64'h77);

    // Reset pulsed low mid-REQ clears everything immediately; a later ack is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 64'h20, 64'h0);
    step();
    chk("mid_req", {63'h0, dm_bus.dm_req}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {63'h0, dm_bus.dm_req}, 64'd0);
    chk("mid_rst_stall", {63'h0, mem_stall}, 64'd0);
    chk("mid_rst_err", {63'h0, mem_err}, 64'd0);
    chk("mid_rst_addr", dm_bus.dm_addr, 64'h0);
    step();
    bubble();
    reset = 1'b1;
    step();
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 64'h1111;
    #1;
    chk("post_rst_stall", {63'h0, mem_stall}, 64'd0);
    step();
    dm_bus.dm_ack = 1'b0;
    chk("post_rst_wb_valid", {63'h0, wb_valid}, 64'd0);
    chk("post_rst_req", {63'h0, dm_bus.dm_req}, 64'd0);

`ifdef MEM_BYTE_ACCESS_EN
    // LDURB at 0x13 selects byte lane 3.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'h13, 64'h0);
    step();
    chk("byte_be", {56'h0, dm_bus.dm_be}, 64'h08);
    chk("byte_addr", dm_bus.dm_addr, 64'h13);
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 64'h8877665544332211;
    #1;
    step();
    dm_bus.dm_ack = 1'b0;
    chk("byte_wb_data", wb_data, 64'h44);
    bubble();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
